// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
// The opcode constants and datapath select codes are kept here so the FSM and the output decoder agree on them.
package ctrl_pkg;

  localparam int OP_WIDTH = 7;
  localparam int F3_WIDTH = 3;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_EXEC_U,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR1,
    S_JALR2
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [1:0] IMM_I  = 2'b00;
  localparam logic [1:0] IMM_S  = 2'b01;
  localparam logic [1:0] IMM_B  = 2'b10;
  localparam logic [1:0] IMM_JU = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEM       = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // funct3 010/011 are not branch conditions in RV32I
  function automatic logic is_bad_branch(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational map from FSM state and instruction fields to every datapath select and strobe.
// All outputs are forced low while reset is asserted.
module ctrl_output_decode
  import ctrl_pkg::*;
#(
  parameter int OP_WIDTH = 7,
  parameter int F3_WIDTH = 3
) (
  input  logic                rst,
  input  state_t              state,
  input  logic [OP_WIDTH-1:0] op,
  input  logic [F3_WIDTH-1:0] funct3,
  input  logic                mem_ready,
  input  logic                branch_cond,
  output logic                mem_req,
  output logic                mem_write,
  output logic                adr_src,
  output logic                ir_write,
  output logic                pc_write,
  output logic                reg_write,
  output logic [1:0]          result_src,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          imm_src,
  output logic                jump_src,
  output logic                instr_done,
  output logic                illegal_op
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned and infers a latch.
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_ADD;
    imm_src    = IMM_I;
    jump_src   = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_req    = 1'b1;
          result_src = RES_ALURESULT;
          alu_src_b  = SRCB_FOUR;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          case (op)
            OPC_BRANCH: imm_src = IMM_B;
            OPC_JAL:    imm_src = IMM_JU;
            OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM,
            OPC_LUI, OPC_AUIPC, OPC_JALR: imm_src = IMM_I;
            default:    illegal_op = 1'b1;
          endcase
        end
        S_MEMADR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          imm_src   = (op == OPC_STORE) ? IMM_S : IMM_I;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEMWB: begin
          result_src = RES_MEM;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req    = 1'b1;
          mem_write  = 1'b1;
          adr_src    = 1'b1;
          instr_done = mem_ready;
        end
        S_EXEC_R: begin
          alu_src_a = SRCA_RS1;
          alu_op    = ALU_FUNCT;
        end
        S_EXEC_I: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALU_FUNCT;
        end
        S_EXEC_U: begin
          imm_src   = IMM_JU;
          jump_src  = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_src_a = (op == OPC_LUI) ? SRCA_ZERO : SRCA_OLDPC;
        end
        S_ALUWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  = SRCA_RS1;
          alu_op     = ALU_SUB;
          instr_done = 1'b1;
          illegal_op = is_bad_branch(funct3);
          pc_write   = branch_cond && !is_bad_branch(funct3);
        end
        S_JAL, S_JALR2: begin
          pc_write  = 1'b1;
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_FOUR;
        end
        S_JALR1: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I core: state register and next-state logic.
// Output decoding lives in ctrl_output_decode.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int OP_WIDTH = 7,
  parameter int F3_WIDTH = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OP_WIDTH-1:0] op,
  input  logic [F3_WIDTH-1:0] funct3,
  input  logic                branch_cond,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_write,
  output logic                adr_src,
  output logic                ir_write,
  output logic                pc_write,
  output logic                reg_write,
  output logic [1:0]          result_src,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          imm_src,
  output logic                jump_src,
  output logic                instr_done,
  output logic                illegal_op
);

  state_t state, next_state;

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:    if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OPC_LOAD, OPC_STORE: next_state = S_MEMADR;
          OPC_OP:              next_state = S_EXEC_R;
          OPC_OP_IMM:          next_state = S_EXEC_I;
          OPC_LUI, OPC_AUIPC:  next_state = S_EXEC_U;
          OPC_BRANCH:          next_state = S_BRANCH;
          OPC_JAL:             next_state = S_JAL;
          OPC_JALR:            next_state = S_JALR1;
          default:             next_state = S_FETCH;
        endcase
      end
      S_MEMADR:   next_state = (op == OPC_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) next_state = S_MEMWB;
      S_MEMWRITE: if (mem_ready) next_state = S_FETCH;
      S_EXEC_R, S_EXEC_I, S_EXEC_U, S_JAL, S_JALR2: next_state = S_ALUWB;
      S_JALR1:    next_state = S_JALR2;
      default:    next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignment so every register samples pre-edge values regardless of block order.
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  ctrl_output_decode #(
    .OP_WIDTH (OP_WIDTH),
    .F3_WIDTH (F3_WIDTH)
  ) u_decode (
    .rst         (rst),
    .state       (state),
    .op          (op),
    .funct3      (funct3),
    .mem_ready   (mem_ready),
    .branch_cond (branch_cond),
    .mem_req     (mem_req),
    .mem_write   (mem_write),
    .adr_src     (adr_src),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .reg_write   (reg_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .imm_src     (imm_src),
    .jump_src    (jump_src),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle comparison of the full output bundle against hand-built vectors.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       branch_cond = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
  logic       jump_src, instr_done, illegal_op;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .funct3      (funct3),
    .branch_cond (branch_cond),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_write   (mem_write),
    .adr_src     (adr_src),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .reg_write   (reg_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .imm_src     (imm_src),
    .jump_src    (jump_src),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op)
  );

  // Bundle order: mem_req mem_write adr_src ir_write pc_write reg_write result_src alu_src_a alu_src_b alu_op imm_src jump_src instr_done illegal_op
  logic [18:0] outs;
  assign outs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                 result_src, alu_src_a, alu_src_b, alu_op, imm_src,
                 jump_src, instr_done, illegal_op};

  function automatic logic [18:0] ov(input logic mreq, mwr, adr, irw, pcw, rw,
                                     input logic [1:0] rs, sa, sb, aop, imm,
                                     input logic js, done, ill);
    return {mreq, mwr, adr, irw, pcw, rw, rs, sa, sb, aop, imm, js, done, ill};
  endfunction

  task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  // Apply inputs for one cycle, compare mid-cycle, then advance past the next rising edge.
  task automatic step(input string tag, input logic [6:0] o, input logic [2:0] f,
                      input logic bc, input logic rdy, input logic [18:0] exp);
    op = o; funct3 = f; branch_cond = bc; mem_ready = rdy;
    @(negedge clk);
    check(tag, outs, exp);
    @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, OPR = 7'b0110011,
                         OPI = 7'b0010011, LUI = 7'b0110111, AUIPC = 7'b0010111,
                         BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111,
                         BAD = 7'b1111111;

  logic [18:0] zero_v, fetch_rdy, fetch_wait, dec_i, dec_b, dec_j, dec_bad;
  logic [18:0] exec_i, exec_r, exec_lui, exec_auipc, aluwb, memadr_l, memadr_s;
  logic [18:0] memrd, memwb, memwr_wait, memwr_rdy, br_t, br_n, br_bad;
  logic [18:0] jal_v, jalr1, jalr2;

  initial begin
    zero_v     = '0;
    fetch_rdy  = ov(1,0,0,1,1,0, 2'b10,2'b00,2'b10,2'b00,2'b00, 0,0,0);
    fetch_wait = ov(1,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b00, 0,0,0);
    dec_i      = ov(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b00, 0,0,0);
    dec_b      = ov(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b10, 0,0,0);
    dec_j      = ov(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b11, 0,0,0);
    dec_bad    = ov(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b00, 0,0,1);
    exec_i     = ov(0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b10,2'b00, 0,0,0);
    exec_r     = ov(0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10,2'b00, 0,0,0);
    exec_lui   = ov(0,0,0,0,0,0, 2'b00,2'b11,2'b01,2'b00,2'b11, 1,0,0);
    exec_auipc = ov(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b11, 1,0,0);
    aluwb      = ov(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,1,0);
    memadr_l   = ov(0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,2'b00, 0,0,0);
    memadr_s   = ov(0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,2'b01, 0,0,0);
    memrd      = ov(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0,0);
    memwb      = ov(0,0,0,0,0,1, 2'b01,2'b00,2'b00,2'b00,2'b00, 0,1,0);
    memwr_wait = ov(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0,0);
    memwr_rdy  = ov(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,1,0);
    br_t       = ov(0,0,0,0,1,0, 2'b00,2'b10,2'b00,2'b01,2'b00, 0,1,0);
    br_n       = ov(0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b01,2'b00, 0,1,0);
    br_bad     = ov(0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b01,2'b00, 0,1,1);
    jal_v      = ov(0,0,0,0,1,0, 2'b00,2'b01,2'b10,2'b00,2'b00, 0,0,0);
    jalr1      = ov(0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,2'b00, 0,0,0);
    jalr2      = ov(0,0,0,0,1,0, 2'b00,2'b01,2'b10,2'b00,2'b00, 0,0,0);

    // Reset: all outputs low even with mem_ready high
    mem_ready = 1'b1;
    @(negedge clk);
    check("reset_outputs", outs, zero_v);
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b0;

    // addi with one fetch wait, then mem_ready ignored (low) in ALUWB
    step("addi_fetch_wait", OPI, 3'b000, 0, 0, fetch_wait);
    step("addi_fetch",      OPI, 3'b000, 0, 1, fetch_rdy);
    step("addi_decode",     OPI, 3'b000, 0, 1, dec_i);
    step("addi_exec_i",     OPI, 3'b000, 0, 1, exec_i);
    step("addi_aluwb",      OPI, 3'b000, 0, 0, aluwb);

    // add (R-type)
    step("add_fetch",  OPR, 3'b000, 0, 1, fetch_rdy);
    step("add_decode", OPR, 3'b000, 0, 1, dec_i);
    step("add_exec_r", OPR, 3'b000, 0, 1, exec_r);
    step("add_aluwb",  OPR, 3'b000, 0, 1, aluwb);

    // lw with three wait cycles in MEMREAD
    step("lw_fetch",   LOAD, 3'b010, 0, 1, fetch_rdy);
    step("lw_decode",  LOAD, 3'b010, 0, 1, dec_i);
    step("lw_memadr",  LOAD, 3'b010, 0, 1, memadr_l);
    for (int i = 0; i < 3; i++) step("lw_memread_wait", LOAD, 3'b010, 0, 0, memrd);
    step("lw_memread_rdy", LOAD, 3'b010, 0, 1, memrd);
    step("lw_memwb",   LOAD, 3'b010, 0, 1, memwb);

    // sw with no wait
    step("sw_fetch",    STORE, 3'b010, 0, 1, fetch_rdy);
    step("sw_decode",   STORE, 3'b010, 0, 1, dec_i);
    step("sw_memadr",   STORE, 3'b010, 0, 1, memadr_s);
    step("sw_memwrite", STORE, 3'b010, 0, 1, memwr_rdy);

    // beq taken, then not taken, then an illegal funct3
    step("beq_t_fetch",  BR, 3'b000, 1, 1, fetch_rdy);
    step("beq_t_decode", BR, 3'b000, 1, 1, dec_b);
    step("beq_t_branch", BR, 3'b000, 1, 1, br_t);
    step("beq_n_fetch",  BR, 3'b000, 0, 1, fetch_rdy);
    step("beq_n_decode", BR, 3'b000, 0, 1, dec_b);
    step("beq_n_branch", BR, 3'b000, 0, 1, br_n);
    step("bbad_fetch",   BR, 3'b010, 1, 1, fetch_rdy);
    step("bbad_decode",  BR, 3'b010, 1, 1, dec_b);
    step("bbad_branch",  BR, 3'b010, 1, 1, br_bad);

    // lui / auipc
    step("lui_fetch",    LUI, 3'b000, 0, 1, fetch_rdy);
    step("lui_decode",   LUI, 3'b000, 0, 1, dec_i);
    step("lui_exec_u",   LUI, 3'b000, 0, 1, exec_lui);
    step("lui_aluwb",    LUI, 3'b000, 0, 1, aluwb);
    step("auipc_fetch",  AUIPC, 3'b000, 0, 1, fetch_rdy);
    step("auipc_decode", AUIPC, 3'b000, 0, 1, dec_i);
    step("auipc_exec_u", AUIPC, 3'b000, 0, 1, exec_auipc);
    step("auipc_aluwb",  AUIPC, 3'b000, 0, 1, aluwb);

    // jal (4 cycles) and jalr (5 cycles)
    step("jal_fetch",   JAL, 3'b000, 0, 1, fetch_rdy);
    step("jal_decode",  JAL, 3'b000, 0, 1, dec_j);
    step("jal_jal",     JAL, 3'b000, 0, 1, jal_v);
    step("jal_aluwb",   JAL, 3'b000, 0, 1, aluwb);
    step("jalr_fetch",  JALR, 3'b000, 0, 1, fetch_rdy);
    step("jalr_decode", JALR, 3'b000, 0, 1, dec_i);
    step("jalr_jalr1",  JALR, 3'b000, 0, 1, jalr1);
    step("jalr_jalr2",  JALR, 3'b000, 0, 1, jalr2);
    step("jalr_aluwb",  JALR, 3'b000, 0, 1, aluwb);

    // Illegal opcode: pulse in DECODE, straight back to FETCH
    step("bad_fetch",       BAD, 3'b000, 0, 1, fetch_rdy);
    step("bad_decode",      BAD, 3'b000, 0, 1, dec_bad);
    step("bad_next_fetch",  OPI, 3'b000, 0, 0, fetch_wait);
    step("bad_fetch_rdy",   OPI, 3'b000, 0, 1, fetch_rdy);
    step("post_bad_decode", OPI, 3'b000, 0, 1, dec_i);
    step("post_bad_exec",   OPI, 3'b000, 0, 1, exec_i);
    step("post_bad_aluwb",  OPI, 3'b000, 0, 1, aluwb);

    // Reset asserted mid-MEMWRITE drops the request in the same cycle
    step("swr_fetch",  STORE, 3'b010, 0, 1, fetch_rdy);
    step("swr_decode", STORE, 3'b010, 0, 1, dec_i);
    step("swr_memadr", STORE, 3'b010, 0, 1, memadr_s);
    mem_ready = 1'b0;
    @(negedge clk);
    check("swr_memwrite_wait", outs, memwr_wait);
    rst = 1'b1;
    #1;
    check("swr_reset_drop", outs, zero_v);
    @(posedge clk); #1;
    rst = 1'b0;
    step("swr_after_reset", STORE, 3'b010, 0, 0, fetch_wait);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
